// File: rtl/cfa_grad_pipe.sv
// CFA edge-direction gradient pipeline: 5x5 window in, scaled H/V gradients and
// smoother-direction flag out, three stages with backpressure and a run FSM.
module cfa_grad_pipe #(
    parameter int unsigned PIX_W = 12,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 6,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       n_win,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [25*PIX_W-1:0]    win,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       grad_hs,
    output logic [OUT_W-1:0]       grad_vs,
    output logic [1:0]             dir,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned SW = PIX_W + 2;
    localparam int unsigned WW = (SW > OUT_W) ? SW : OUT_W;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_win_q, n_win_d;

    logic en;
    logic accept;

    logic                 v1_q, v2_q, ov_q;
    logic signed [SW-1:0] dh1_d, dh2_d, dv1_d, dv2_d;
    logic signed [SW-1:0] dh1_q, dh2_q, dv1_q, dv2_q;
    logic [SW-1:0]        h_d, v_d, h_q, v_q;
    logic [OUT_W-1:0]     hs_q, vs_q;
    logic [1:0]           dir_d, dir_q;

    function automatic logic [SW-1:0] px(input logic [25*PIX_W-1:0] w,
                                         input int unsigned r, input int unsigned c);
        return SW'(w[(r*5+c)*PIX_W +: PIX_W]);
    endfunction

    function automatic logic [SW-1:0] sabs(input logic signed [SW-1:0] d);
        return d[SW-1] ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic [SW-1:0] x);
        logic [WW-1:0] s;
        s = WW'(x >> SHIFT);
        if (s > WW'({OUT_W{1'b1}})) begin
            return {OUT_W{1'b1}};
        end
        return OUT_W'(s);
    endfunction

    assign en       = !ov_q || out_ready;
    assign in_ready = en && (state_q == StRun);
    assign accept   = in_valid && in_ready;

    // S1: operands are zero-extended by two bits, so signed differences never overflow.
    always_comb begin
        dh1_d = $signed(px(win, 2, 1)) - $signed(px(win, 2, 3));
        dv1_d = $signed(px(win, 1, 2)) - $signed(px(win, 3, 2));
        dh2_d = $signed(px(win, 2, 2) << 1) - $signed(px(win, 2, 0)) - $signed(px(win, 2, 4));
        dv2_d = $signed(px(win, 2, 2) << 1) - $signed(px(win, 0, 2)) - $signed(px(win, 4, 2));
        if (mode) begin
            dh2_d = '0;
            dv2_d = '0;
        end
    end

    // S2 / S3 combinational parts.
    always_comb begin
        h_d = sabs(dh1_q) + sabs(dh2_q);
        v_d = sabs(dv1_q) + sabs(dv2_q);
        if (h_q < v_q) begin
            dir_d = 2'd0;
        end else if (v_q < h_q) begin
            dir_d = 2'd1;
        end else begin
            dir_d = 2'd2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            ov_q  <= 1'b0;
            dh1_q <= '0;
            dh2_q <= '0;
            dv1_q <= '0;
            dv2_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= '0;
            vs_q  <= '0;
            dir_q <= 2'd0;
        end else if (en) begin
            v1_q  <= accept;
            dh1_q <= dh1_d;
            dh2_q <= dh2_d;
            dv1_q <= dv1_d;
            dv2_q <= dv2_d;
            v2_q  <= v1_q;
            h_q   <= h_d;
            v_q   <= v_d;
            ov_q  <= v2_q;
            hs_q  <= sat(h_q);
            vs_q  <= sat(v_q);
            dir_q <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_win_d = n_win_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    n_win_d = n_win;
                    cnt_d   = '0;
                    state_d = (n_win == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == n_win_q - 1'b1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Leave as the pipeline empties, so done follows the final take by one cycle.
                if (!v1_q && !v2_q && (!ov_q || out_ready)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            n_win_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_win_q <= n_win_d;
        end
    end

    assign out_valid = ov_q;
    assign grad_hs   = hs_q;
    assign grad_vs   = vs_q;
    assign dir       = dir_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign done      = (state_q == StDone);

endmodule

// File: tb/tb_cfa_grad_pipe.sv
// Self-checking bench for cfa_grad_pipe: vector table plus scoreboard, with a
// SHIFT=0 instance run in parallel for the saturation case.
module tb_cfa_grad_pipe;

    localparam int PIX_W = 12;
    localparam int OUT_W = 8;
    localparam int CNT_W = 16;
    localparam int WW    = 25 * PIX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] n_win = '0;
    logic             mode = 1'b0;
    logic             in_valid = 1'b0;
    logic [WW-1:0]    win = '0;
    logic             out_ready = 1'b1;
    logic             ready_val = 1'b1;
    logic             stall_en = 1'b0;

    logic             in_ready_a, out_valid_a, busy_a, done_a;
    logic [OUT_W-1:0] hs_a, vs_a;
    logic [1:0]       dir_a;
    logic             in_ready_b, out_valid_b, busy_b, done_b;
    logic [OUT_W-1:0] hs_b, vs_b;
    logic [1:0]       dir_b;

    always #5 clk = ~clk;

    cfa_grad_pipe #(.PIX_W(12), .OUT_W(8), .SHIFT(6), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .n_win(n_win), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_a), .win(win),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .grad_hs(hs_a), .grad_vs(vs_a), .dir(dir_a), .busy(busy_a), .done(done_a)
    );

    cfa_grad_pipe #(.PIX_W(12), .OUT_W(8), .SHIFT(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .n_win(n_win), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready_b), .win(win),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .grad_hs(hs_b), .grad_vs(vs_b), .dir(dir_b), .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic [OUT_W-1:0] hs;
        logic [OUT_W-1:0] vs;
        logic [1:0]       dir;
    } exp_t;

    typedef struct {
        logic [WW-1:0]    w;
        logic             m;
        logic [OUT_W-1:0] hs;
        logic [OUT_W-1:0] vs;
        logic [1:0]       dir;
    } vec_t;

    vec_t tab[8];
    vec_t cur;
    logic use_tab = 1'b0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    int ov_cnt = 0;
    int done_cnt = 0;
    int cyc_n = 0;
    int last_take = 0;
    logic             stalled = 1'b0;
    logic [OUT_W-1:0] hold_hs, hold_vs;
    logic [1:0]       hold_dir;
    logic [3:0]       pat = 4'b1001;
    int               pidx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] px(input int r, input int c, input int v);
        logic [WW-1:0] x;
        x = '0;
        x[(r*5+c)*PIX_W +: PIX_W] = v[PIX_W-1:0];
        return x;
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic exp_t model(input logic [WW-1:0] w, input logic m, input int sh);
        int   p[5][5];
        int   h, v;
        exp_t e;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                p[r][c] = int'(w[(r*5+c)*PIX_W +: PIX_W]);
        h = iabs(p[2][1] - p[2][3]) + (m ? 0 : iabs(2*p[2][2] - p[2][0] - p[2][4]));
        v = iabs(p[1][2] - p[3][2]) + (m ? 0 : iabs(2*p[2][2] - p[0][2] - p[4][2]));
        e.hs  = ((h >> sh) > 255) ? 8'd255 : 8'(h >> sh);
        e.vs  = ((v >> sh) > 255) ? 8'd255 : 8'(v >> sh);
        e.dir = (h < v) ? 2'd0 : ((v < h) ? 2'd1 : 2'd2);
        return e;
    endfunction

    function automatic logic [WW-1:0] rnd_win();
        logic [WW-1:0] w;
        for (int i = 0; i < 25; i++) w[i*PIX_W +: PIX_W] = 12'($urandom);
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [WW-1:0] w, input logic m, input logic ut);
        int k;
        k = 0;
        win = w;
        mode = m;
        use_tab = ut;
        in_valid = 1'b1;
        while (!in_ready_a && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) chk("send_timeout", 0, 1);
        cyc();
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done_a && k < 300) begin
            cyc();
            k++;
        end
        chk(name, done_a, 1);
    endtask

    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (stall_en) begin
            out_ready = pat[pidx];
            pidx = (pidx + 1) % 4;
        end else begin
            out_ready = ready_val;
        end
    end

    // Scoreboard: push on accept, pop on take, hold check on stall.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", out_valid_a, 1);
                chk("hold_hs", hs_a, hold_hs);
                chk("hold_vs", vs_a, hold_vs);
                chk("hold_dir", dir_a, hold_dir);
            end
            if (out_valid_a) ov_cnt++;
            if (out_valid_a && out_ready) begin
                out_cnt++;
                last_take = cyc_n;
                chk("b_valid", out_valid_b, 1);
                if (q_a.size() == 0 || q_b.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = q_a.pop_front();
                    chk("out_hs", hs_a, mon_e.hs);
                    chk("out_vs", vs_a, mon_e.vs);
                    chk("out_dir", dir_a, mon_e.dir);
                    mon_e = q_b.pop_front();
                    chk("s0_hs", hs_b, mon_e.hs);
                    chk("s0_vs", vs_b, mon_e.vs);
                    chk("s0_dir", dir_b, mon_e.dir);
                end
            end
            stalled  = out_valid_a && !out_ready;
            hold_hs  = hs_a;
            hold_vs  = vs_a;
            hold_dir = dir_a;
            if (in_valid && in_ready_a) begin
                acc_cnt++;
                if (use_tab) begin
                    mon_e.hs  = cur.hs;
                    mon_e.vs  = cur.vs;
                    mon_e.dir = cur.dir;
                end else begin
                    mon_e = model(win, mode, 6);
                end
                q_a.push_back(mon_e);
                q_b.push_back(model(win, mode, 0));
            end
            if (done_a) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a0, o0, d0, v0;
        tab[0] = '{px(2, 2, 4095), 1'b0, 8'd127, 8'd127, 2'd2};
        tab[1] = '{px(2, 3, 4095), 1'b0, 8'd63, 8'd0, 2'd1};
        tab[2] = '{px(2, 3, 4095), 1'b1, 8'd63, 8'd0, 2'd1};
        tab[3] = '{px(2, 1, 100) | px(2, 3, 36) | px(2, 0, 10) | px(2, 2, 50),
                   1'b0, 8'd2, 8'd1, 2'd1};
        tab[4] = '{px(1, 2, 4095) | px(0, 2, 4095) | px(4, 2, 4095), 1'b0, 8'd0, 8'd191, 2'd0};
        tab[5] = '{px(1, 2, 4095) | px(0, 2, 4095) | px(4, 2, 4095), 1'b1, 8'd0, 8'd63, 2'd0};
        tab[6] = '{px(2, 0, 4095) | px(2, 4, 4095), 1'b0, 8'd127, 8'd0, 2'd1};
        tab[7] = '{'0, 1'b0, 8'd0, 8'd0, 2'd2};

        // Reset state
        repeat (3) cyc();
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_hs", hs_a, 0);
        chk("rst_vs", vs_a, 0);
        chk("rst_dir", dir_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_in_ready", in_ready_a, 0);
        chk("rst_b_idle", {out_valid_b, busy_b, done_b, in_ready_b}, 0);
        rst = 1'b0;
        cyc();

        // Scenario 1: single window, latency and done timing
        start = 1'b1;
        n_win = 16'd1;
        cyc();
        start = 1'b0;
        chk("s1_busy", busy_a, 1);
        cur = tab[0];
        send(tab[0].w, tab[0].m, 1'b1);
        in_valid = 1'b0;
        use_tab = 1'b0;
        lat = 1;
        while (!out_valid_a && lat < 10) begin
            cyc();
            lat++;
        end
        chk("s1_latency", lat, 3);
        chk("s3_sat_hs", hs_b, 255);
        chk("s3_sat_vs", vs_b, 255);
        cyc();
        chk("s1_done", done_a, 1);
        chk("s1_busy_low", busy_a, 0);
        cyc();
        chk("s1_done_once", done_a, 0);

        // Vector table, back to back
        o0 = out_cnt;
        start = 1'b1;
        n_win = 16'd8;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cur = tab[i];
            send(tab[i].w, tab[i].m, 1'b1);
        end
        in_valid = 1'b0;
        use_tab = 1'b0;
        wait_done("tab_done");
        chk("tab_count", out_cnt - o0, 8);
        cyc();

        // Scenario 4: out_ready 1,0,0,1 with in_valid held
        o0 = out_cnt;
        a0 = acc_cnt;
        d0 = done_cnt;
        stall_en = 1'b1;
        start = 1'b1;
        n_win = 16'd4;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 4; i++) send(rnd_win(), 1'($urandom), 1'b0);
        chk("s4_in_ready_low", in_ready_a, 0);
        chk("s4_busy", busy_a, 1);
        wait_done("s4_done");
        chk("s4_done_after_take", cyc_n - last_take, 1);
        chk("s4_outputs", out_cnt - o0, 4);
        chk("s4_accepts", acc_cnt - a0, 4);
        chk("s4_busy_low", busy_a, 0);
        in_valid = 1'b0;
        stall_en = 1'b0;
        repeat (5) cyc();
        chk("s4_done_pulses", done_cnt - d0, 1);

        // Scenario 5: n_win = 0
        a0 = acc_cnt;
        in_valid = 1'b1;
        win = rnd_win();
        start = 1'b1;
        n_win = 16'd0;
        cyc();
        start = 1'b0;
        chk("s5_done", done_a, 1);
        chk("s5_busy", busy_a, 0);
        chk("s5_in_ready", in_ready_a, 0);
        cyc();
        chk("s5_done_once", done_a, 0);
        chk("s5_busy_after", busy_a, 0);
        chk("s5_accepts", acc_cnt - a0, 0);
        in_valid = 1'b0;
        cyc();

        // Scenario 6: reset mid-run
        start = 1'b1;
        n_win = 16'd5;
        cyc();
        start = 1'b0;
        send(rnd_win(), 1'b0, 1'b0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("s6_out_valid", out_valid_a, 0);
        chk("s6_outs_zero", {hs_a, vs_a, dir_a}, 0);
        chk("s6_busy", busy_a, 0);
        chk("s6_done", done_a, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        v0 = ov_cnt;
        d0 = done_cnt;
        repeat (10) cyc();
        chk("s6_no_valid", ov_cnt - v0, 0);
        chk("s6_no_done", done_cnt - d0, 0);
        o0 = out_cnt;
        start = 1'b1;
        n_win = 16'd3;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) send(rnd_win(), 1'($urandom), 1'b0);
        in_valid = 1'b0;
        wait_done("s6_rerun_done");
        chk("s6_rerun_count", out_cnt - o0, 3);
        cyc();

        chk("sb_a_empty", q_a.size(), 0);
        chk("sb_b_empty", q_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cfa_grad_pipe.md
CFA_GRAD_PIPE -- requirements
Module: cfa_grad_pipe

Interface
REQ-001 The module SHALL have a parameter PIX_W, default 12, giving the pixel width in bits.
REQ-002 The module SHALL have a parameter OUT_W, default 8, giving the gradient output width in bits.
REQ-003 The module SHALL have a parameter SHIFT, default 6, giving the right-shift applied to the raw gradient before saturation.
REQ-004 The module SHALL have a parameter CNT_W, default 16, giving the window-count width in bits.
REQ-005 The module SHALL use one clock; reset is synchronous and active-high.
REQ-006 The port list SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle run request.
- n_win  in  CNT_W  number of windows in the run; sampled on accepted start.
- mode  in  1  0 = full gradient (1st + 2nd order), 1 = 1st order only; sampled per window with win.
- in_valid  in  1  window valid.
- in_ready  out  1  window accept.
- win  in  25*PIX_W  5x5 window; element (r,c), r = row 0..4 top-down, c = col 0..4 left-right, at bits (r*5+c)*PIX_W +: PIX_W, unsigned.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- grad_hs  out  OUT_W  horizontal gradient, scaled and saturated.
- grad_vs  out  OUT_W  vertical gradient, scaled and saturated.
- dir  out  2  0 = horizontal smoother, 1 = vertical smoother, 2 = tie.
- busy  out  1  run in progress.
- done  out  1  one-cycle end-of-run pulse.

Function
REQ-007 The raw horizontal gradient SHALL be H = |w(2,1) - w(2,3)| + m*|2*w(2,2) - w(2,0) - w(2,4)|, where m = 1 when mode = 0 and m = 0 when mode = 1.
REQ-008 The raw vertical gradient SHALL be V = |w(1,2) - w(3,2)| + m*|2*w(2,2) - w(0,2) - w(4,2)|, with m defined as in REQ-007.
REQ-009 The 2nd-order difference SHALL be computed signed at PIX_W+2 bits, and the sums H and V SHALL be held at PIX_W+2 bits unsigned, so that no intermediate overflows.
REQ-010 The value of grad_hs SHALL be min(H >> SHIFT, 2^OUT_W - 1), and grad_vs SHALL be formed the same way from V.
REQ-011 The value of dir SHALL be computed from the unscaled H and V: 0 if H < V, 1 if V < H, 2 if H == V.
REQ-012 The datapath SHALL be a 3-stage pipeline: S1 differences, S2 absolute values and sums, S3 scale/saturate/compare and output register.
REQ-013 A window accepted in cycle t SHALL produce out_valid in cycle t+3 when no stall occurs; sustained throughput SHALL be one window per cycle.
REQ-014 The pipeline enable SHALL be en = !out_valid | out_ready, and all stages SHALL advance only when en = 1.
REQ-015 A window SHALL be accepted when in_valid & in_ready, with in_ready = en & (state == RUN).
REQ-016 While out_valid = 1 and out_ready = 0, grad_hs, grad_vs and dir SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-017 Valid bits SHALL travel with the data so that bubbles propagate without producing outputs.
REQ-018 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-019 In IDLE, start SHALL latch n_win and move to RUN, or move directly to DONE if n_win = 0.
REQ-020 In RUN, acceptances SHALL be counted, and acceptance of the n_win-th window SHALL move the FSM to DRAIN.
REQ-021 In DRAIN, in_ready SHALL be 0, and the FSM SHALL move to DONE when no stage holds a valid window and out_valid = 0.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 Assertion of start outside IDLE SHALL be ignored.
REQ-024 The busy output SHALL be 1 in RUN and DRAIN and 0 otherwise.
REQ-025 The window counter SHALL be CNT_W bits wide; n_win = 2^CNT_W - 1 SHALL be legal and SHALL NOT wrap.

Reset
REQ-026 With rst = 1 at a clock edge, the FSM SHALL go to IDLE, the counter and all stage valid bits SHALL clear, and out_valid, grad_hs, grad_vs, dir, busy and done SHALL all be 0.
REQ-027 An rst asserted mid-run SHALL discard in-flight windows, and no done pulse SHALL follow for the aborted run.

Verification
REQ-028 Scenario 1: defaults, n_win = 1, mode 0, all-zero window with w(2,2) = 4095 -> grad_hs = 127, grad_vs = 127, dir = 2, out_valid 3 cycles after accept, done 1 cycle after the output is taken.
REQ-029 Scenario 2: all-zero window with w(2,3) = 4095, mode 0 -> H = 4095, grad_hs = 63, grad_vs = 0, dir = 1; the same window with mode 1 -> identical output.
REQ-030 Scenario 3: SHIFT = 0 instance, the window from Scenario 1 -> H = V = 8190, and grad_hs = grad_vs = 255 (saturated).
REQ-031 Scenario 4: n_win = 4, in_valid held at 1, out_ready toggled 1,0,0,1,... -> exactly 4 outputs in order with values held while stalled; in_ready is 0 after the 4th acceptance; busy falls and done pulses once after the last output is taken.
REQ-032 Scenario 5: start with n_win = 0 -> done pulses in the next cycle, no window is accepted, and busy is never 1.
REQ-033 Scenario 6: rst asserted 2 cycles after the first acceptance of an n_win = 5 run -> all outputs are 0 the next cycle, no out_valid or done is produced, and a new start runs normally.
